// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and a small helper for the bit counter width.
package serial_subtractor_pkg;

    // 2-bit state encoding; the unused code 3 is treated as IDLE by the FSM.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed for a counter that must be able to hold the value width.
    function automatic int cnt_bits(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
// Purely combinational so it can be shared by other serial subtract paths.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow out for one bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (A - B) mod 2^WIDTH, LSB first,
// one bit per clock through a single full-subtractor cell and a borrow flop.
// Results are registered and only change on the completion edge.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold the last result
// S_SHIFT | one operand bit consumed per clock, WIDTH clocks in total
// S_DONE  | done pulse cycle; a start seen here begins the next op
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   d_sr;
    logic [WIDTH-1:0]   d_sr_next;
    logic               bflop;
    logic [CNT_W-1:0]   cnt;

    logic               fs_d;
    logic               fs_bout;
    logic               last_bit;

    logic               load;
    logic               shift_en;
    logic               finish;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bflop),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign last_bit  = (cnt == LAST_CNT);
    // New difference bit enters at the MSB so the LSB ends up at bit 0.
    assign d_sr_next = (d_sr >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));
    assign busy      = (state_q != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and datapath strobes.
    // Accepting start in S_DONE gives back-to-back ops every WIDTH+1 clocks.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
                    finish  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand shift registers, borrow flop, bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr  <= '0;
            b_sr  <= '0;
            d_sr  <= '0;
            bflop <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sr  <= A;
            b_sr  <= B;
            d_sr  <= '0;
            bflop <= 1'b0;
            cnt   <= '0;
        end else if (shift_en) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            d_sr  <= d_sr_next;
            bflop <= fs_bout;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result registers and done pulse; updated only on the completion edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            diff   <= '0;
            borrow <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (finish) begin
                diff   <= d_sr_next;
                borrow <= fs_bout;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance driven from a
// vector table plus handshake corner sequences, and a 1-bit instance
// checked exhaustively.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] diff8;
    logic       borrow8;
    logic       busy8;
    logic       done8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] diff1;
    logic       borrow1;
    logic       busy1;
    logic       done1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .start  (start8),
        .A      (a8),
        .B      (b8),
        .diff   (diff8),
        .borrow (borrow8),
        .busy   (busy8),
        .done   (done8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .start  (start1),
        .A      (a1),
        .B      (b1),
        .diff   (diff1),
        .borrow (borrow1),
        .busy   (busy1),
        .done   (done1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One complete operation on the 8-bit instance, starting from IDLE.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eb);
        int lat;
        int bc;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        bc  = 0;
        while (!done8 && lat < 50) begin
            if (busy8) bc++;
            @(negedge clk);
            lat++;
        end
        if (busy8) bc++;
        check($sformatf("op8 %0d-%0d latency", a, b), lat, 8);
        check($sformatf("op8 %0d-%0d diff", a, b), diff8, ed);
        check($sformatf("op8 %0d-%0d borrow", a, b), borrow8, eb);
        check($sformatf("op8 %0d-%0d busy cycles", a, b), bc, 9);
        @(negedge clk);
        check("op8 done width", done8, 0);
        check("op8 idle after", busy8, 0);
    endtask

    task automatic do_op1(input logic a, input logic b, input logic ed, input logic eb);
        int lat;
        @(negedge clk);
        a1 = a; b1 = b; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("op1 %0d-%0d latency", a, b), lat, 1);
        check($sformatf("op1 %0d-%0d diff", a, b), diff1, ed);
        check($sformatf("op1 %0d-%0d borrow", a, b), borrow1, eb);
        @(negedge clk);
        check("op1 done width", done1, 0);
    endtask

    initial begin
        int ndone;
        vecs[0] = '{a: 8'd5,   b: 8'd3,   d: 8'd2,   bo: 1'b0};
        vecs[1] = '{a: 8'd3,   b: 8'd5,   d: 8'd254, bo: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd0,   d: 8'd0,   bo: 1'b0};
        vecs[3] = '{a: 8'hFF,  b: 8'h00,  d: 8'hFF,  bo: 1'b0};
        vecs[4] = '{a: 8'h00,  b: 8'hFF,  d: 8'h01,  bo: 1'b1};
        vecs[5] = '{a: 8'h80,  b: 8'h01,  d: 8'h7F,  bo: 1'b0};
        vecs[6] = '{a: 8'd100, b: 8'd200, d: 8'd156, bo: 1'b1};
        vecs[7] = '{a: 8'hAA,  b: 8'h55,  d: 8'h55,  bo: 1'b0};

        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset diff", diff8, 0);
        check("reset borrow", borrow8, 0);
        check("reset busy", busy8, 0);
        check("reset done", done8, 0);

        for (int i = 0; i < 8; i++) begin
            do_op8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo);
        end

        // Back-to-back with start held; operands disturbed mid-shift.
        @(negedge clk);
        a8 = 8'd10; b8 = 8'd4; start8 = 1'b1;
        ndone = 0;
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            if (n == 3) begin a8 = 8'd99; b8 = 8'd1; end
            if (n == 6) begin a8 = 8'd10; b8 = 8'd4; end
            check($sformatf("b2b done n=%0d", n), done8, (n % 9 == 8) ? 1 : 0);
            check($sformatf("b2b busy n=%0d", n), busy8, 1);
            if (done8) begin
                ndone++;
                check($sformatf("b2b diff n=%0d", n), diff8, 6);
            end
            if (n == 35) start8 = 1'b0;
        end
        check("b2b done count", ndone, 4);
        @(negedge clk);
        check("b2b idle after", busy8, 0);

        // Start pulse during SHIFT is ignored; previous result holds.
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd8; start8 = 1'b1;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (n == 3) begin a8 = 8'd7; b8 = 8'd9; start8 = 1'b1; end
            if (n < 8) check($sformatf("ign hold n=%0d", n), diff8, 6);
            if (done8) begin
                ndone++;
                check("ign done pos", n, 8);
                check("ign diff", diff8, 42);
                check("ign borrow", borrow8, 0);
            end
            if (n == 10) check("ign idle", busy8, 0);
        end
        check("ign done count", ndone, 1);

        // Reset mid-operation discards the op.
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
        ndone = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) ndone++;
            if (n == 3) reset = 1'b1;
        end
        check("rst busy", busy8, 0);
        check("rst done", done8, 0);
        check("rst diff", diff8, 0);
        check("rst borrow", borrow8, 0);
        check("rst no done", ndone, 0);
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("rst no late done", ndone, 0);
        do_op8(8'd200, 8'd100, 8'd100, 1'b0);

        // WIDTH=1 instance, exhaustive.
        do_op1(1'b0, 1'b0, 1'b0, 1'b0);
        do_op1(1'b1, 1'b0, 1'b1, 1'b0);
        do_op1(1'b0, 1'b1, 1'b1, 1'b1);
        do_op1(1'b1, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
